cdc_hs_tx_ctrl: RTL

- Transmit-side controller for a 4-phase req/ack handshake carrying a multi-bit word across clock domains (e.g. PUF challenge/response words).
- Accepts a word on a valid/ready interface and holds it stable on xfer_data.
- Sequences xfer_req against an ack returned asynchronously from the far domain; the ack is synchronized internally by a multi-flop synchronizer.
- Sits between the local datapath and the far-domain receiver, which samples xfer_data through its own req synchronizer.

---
 rtl/cdc_hs_pkg.sv | 24 ++
 rtl/cdc_hs_tx_ctrl_sync_chain.sv | 26 ++
 rtl/cdc_hs_tx_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cdc_hs_pkg.sv
// Shared types and default constants for the 4-phase req/ack transmit controller.
//   hs_state_t      : controller state encoding
//   DEF_DATA_W      : default transferred word width
//   DEF_SYNC_STAGES : default depth of the ack synchronizer
//   DEF_TIMEOUT_CYC : default wait limit per handshake phase
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2,
    ERR    = 2'd3
  } hs_state_t;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT_CYC = 1024;

  // Counter width able to hold TIMEOUT_CYC-1.
  function automatic int cnt_w(input int cyc);
    return (cyc > 2) ? $clog2(cyc) : 1;
  endfunction

endpackage

// File: rtl/cdc_hs_tx_ctrl_sync_chain.sv
// sync_chain: STAGES-deep flop chain for bringing an asynchronous signal
// into the clk domain. Every flop resets to 0.
//   clk   : destination clock
//   reset : asynchronous, active-low
//   d     : asynchronous input (W bits, each bit synchronized independently)
//   q     : synchronized output, STAGES cycles behind d
module sync_chain #(
  parameter int STAGES = 2,
  parameter int W      = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx_ctrl.sv
// cdc_hs_tx_ctrl: transmit side of a 4-phase req/ack handshake moving a
// DATA_W-bit word into a far clock domain.
//   clk, reset   : local clock, asynchronous active-low reset
//   in_valid/in_ready/in_data : local word intake (in_ready combinational)
//   xfer_req     : registered request to far domain
//   xfer_data    : registered word, held stable for the whole handshake
//   xfer_ack     : far-domain ack, asynchronous, synchronized internally
//   busy         : state != IDLE
//   timeout_err  : sticky phase-timeout flag
//   err_clr      : clears timeout_err and leaves ERR once ack is low
// Optional feature: define CDC_HS_TIMEOUT_EN to build the per-phase timeout
// counter and ERR state. Without it, timeout_err is tied low, err_clr is
// ignored and both handshake phases wait indefinitely.
module cdc_hs_tx_ctrl
  import cdc_hs_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              xfer_req,
  output logic [DATA_W-1:0] xfer_data,
  input  logic              xfer_ack,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr
);

  hs_state_t state, state_nxt;
  logic      ack_s;
  logic      req_nxt;
  logic      ld;
  logic      accept;

  sync_chain #(.STAGES(SYNC_STAGES), .W(1)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (xfer_ack),
    .q     (ack_s)
  );

  // Refusing intake while ack_s is still high keeps a new request from
  // overlapping the tail of the previous handshake.
  assign in_ready = (state == IDLE) && !ack_s;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

`ifdef CDC_HS_TIMEOUT_EN
  localparam int CW = cnt_w(TIMEOUT_CYC);

  logic [CW-1:0] cnt;
  logic          tmo_hit;
  logic          err_nxt;

  assign tmo_hit = (cnt == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_nxt = state;
    req_nxt   = xfer_req;
    ld        = 1'b0;
    err_nxt   = timeout_err;
    case (state)
      IDLE: if (accept) begin
        ld        = 1'b1;
        req_nxt   = 1'b1;
        state_nxt = REQ_HI;
      end
      // Exit test comes first so an ack arriving on the terminal count wins.
      REQ_HI: if (ack_s) begin
        req_nxt   = 1'b0;
        state_nxt = REQ_LO;
      end else if (tmo_hit) begin
        req_nxt   = 1'b0;
        err_nxt   = 1'b1;
        state_nxt = ERR;
      end
      REQ_LO: if (!ack_s) begin
        state_nxt = IDLE;
      end else if (tmo_hit) begin
        err_nxt   = 1'b1;
        state_nxt = ERR;
      end
      ERR: begin
        req_nxt = 1'b0;
        // Leaving with ack still high would let the far side see a stale
        // handshake phase, so the clear waits for ack to settle low.
        if (err_clr && !ack_s) begin
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Counts cycles spent in the current waiting phase; restarts on any move.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     cnt <= '0;
    else if (state_nxt != state)                    cnt <= '0;
    else if ((state == REQ_HI) || (state == REQ_LO)) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timeout_err <= 1'b0;
    else        timeout_err <= err_nxt;
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign timeout_err    = 1'b0;

  always_comb begin
    state_nxt = state;
    req_nxt   = xfer_req;
    ld        = 1'b0;
    case (state)
      IDLE: if (accept) begin
        ld        = 1'b1;
        req_nxt   = 1'b1;
        state_nxt = REQ_HI;
      end
      REQ_HI: if (ack_s) begin
        req_nxt   = 1'b0;
        state_nxt = REQ_LO;
      end
      REQ_LO: if (!ack_s) state_nxt = IDLE;
      default: begin
        req_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Data and req load on the same edge; the receiver's req synchronizer
  // delay guarantees data is settled before it samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xfer_req  <= 1'b0;
      xfer_data <= '0;
    end else begin
      xfer_req <= req_nxt;
      if (ld) xfer_data <= in_data;
    end
  end

endmodule
